hyperbus_trans_arbiter: RTL and testbench
=========================================

HYPERBUS_TRANS_ARBITER -- requirements
Module: hyperbus_trans_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2, number of requesters sharing one PHY interface (minimum 1).
REQ-002 SHALL have parameter NumChips, default 2, chip-select width per transaction.
REQ-003 SHALL have parameters hyper_tx_t / hyper_rx_t, default logic, TX/RX beat types (fields data, strb, last / data, last, error).
REQ-004 clk_i  input  1  clock; all state on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 req_trans_valid_i / req_trans_ready_o  in/out  NumReq  per-requester transaction handshake.
REQ-007 req_trans_i  input  NumReq x hyper_tf_t  per-requester transaction; req_cs_i  input  NumReq x NumChips  chip selects.
REQ-008 req_tx_valid_i / req_tx_ready_o  in/out  NumReq; req_tx_i  input  NumReq x hyper_tx_t  write beats.
REQ-009 req_rx_valid_o / req_rx_ready_i  out/in  NumReq; rx_o  output  hyper_rx_t  read beats, shared, qualified by req_rx_valid_o.
REQ-010 req_b_valid_o / req_b_ready_i  out/in  NumReq; b_error_o  output  1  shared write response.
REQ-011 trans_valid_o / trans_ready_i, trans_o (hyper_tf_t), trans_cs_o (NumChips)  PHY-facing transaction channel.
REQ-012 tx_valid_o / tx_ready_i, tx_o; rx_valid_i / rx_ready_o, rx_i; b_valid_i / b_ready_o, b_error_i  PHY-facing channels.
REQ-013 busy_o  output  1  high whenever state is not IDLE; grant_o  output  $clog2(NumReq) (min 1)  current grant index.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WRITE, WAIT_B, READ.
REQ-015 IDLE: if any req_trans_valid_i is set, select the first valid index at or after rr_ptr (wrapping), register it as grant, go to ISSUE; arbitration latency exactly 1 cycle.
REQ-016 ISSUE: trans_valid_o = req_trans_valid_i[grant]; trans_o/trans_cs_o from grant; req_trans_ready_o[grant] = trans_ready_i; on handshake go WRITE if trans_o.write, else READ.
REQ-017 WRITE: tx channel muxed from grant; on tx handshake with last=1 go WAIT_B.
REQ-018 WAIT_B: b channel routed to grant only; on b handshake go IDLE.
REQ-019 READ: rx channel routed to grant only; on rx handshake with rx_i.last=1 go IDLE; rx_i.error passed unmodified.
REQ-020 On every return to IDLE SHALL set rr_ptr = grant+1, wrapping to 0 at NumReq.
REQ-021 Non-granted requesters SHALL see all ready/valid outputs low; PHY-facing valids/readies SHALL be low in states where the channel is not routed.
REQ-022 A b or rx beat arriving in a state that does not route it SHALL NOT be acknowledged (ready held low).
REQ-023 Requester dropping req_trans_valid_i in ISSUE before handshake is a protocol violation; the block holds ISSUE and keeps trans_valid_o tracking the input.
REQ-024 All routing is combinational from registered state; no added data latency on tx/rx/b.
REQ-025 NumReq=1 SHALL degenerate to a pass-through sequencer, grant_o constant 0.

Reset
REQ-026 On reset: state IDLE, grant 0, rr_ptr 0; all valid/ready outputs 0, busy_o 0.
REQ-027 Reset mid-transaction SHALL abandon it immediately; no beats or responses emitted afterwards for it.

Structure
REQ-028 State enum and any arbiter constants SHALL live in hyperbus_pkg; hyper_tf_t reused from hyperbus_pkg.
REQ-029 Round-robin selection MAY use the common rr_arb_tree sub-module in lock-in mode; otherwise a single flat module.

Verification
REQ-030 Req0 write, 4 beats, last on beat 4, b_error_i=0 -> trans handshake 1 cycle after request, 4 tx beats forwarded, req_b_valid_o[0] then IDLE, rr_ptr=1.
REQ-031 Req0 and req1 request simultaneously from reset -> req0 served first, req1 second; then both again -> req0 after req1 (fairness).
REQ-032 Req1 read of 8 beats, rx_ready stalled every other cycle -> 8 beats delivered in order to req1 only, req_rx_valid_o[0] never high.
REQ-033 Read with rx_i.error=1 on beat 3 -> error visible to requester on beat 3, transfer continues to last.
REQ-034 Reset asserted in WRITE after beat 2 -> next cycle all outputs 0, busy_o 0; new request served normally after release.
REQ-035 b_valid_i asserted during READ -> b_ready_o stays 0 until WAIT_B of a write.

Source files
------------

// File: rtl/hyperbus_pkg.sv
// Shared HyperBus types for the transaction arbiter.
//   hyper_tf_t       : transaction descriptor (direction, address, burst length)
//   hyper_tx_beat_t  : default write beat (data, strb, last)
//   hyper_rx_beat_t  : default read beat (data, last, error)
//   arb_state_e      : arbiter FSM states
package hyperbus_pkg;

  typedef struct packed {
    logic        write;
    logic [31:0] address;
    logic [15:0] burst;
  } hyper_tf_t;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  strb;
    logic        last;
  } hyper_tx_beat_t;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        error;
  } hyper_rx_beat_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWrite,
    StWaitB,
    StRead
  } arb_state_e;

  // Grant index width; a single requester still needs a 1-bit index.
  function automatic int unsigned grant_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/hyperbus_trans_arbiter_rr.sv
// Round-robin selector: picks the first set bit of `valid` at or after `ptr`,
// wrapping to index 0.
//   valid : request vector
//   ptr   : round-robin start index
//   sel   : selected index (0 when none valid)
//   any   : at least one request valid
module hyperbus_trans_arbiter_rr
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  localparam int unsigned GrantW = grant_width(NumReq)
) (
  input  logic [NumReq-1:0] valid,
  input  logic [GrantW-1:0] ptr,
  output logic [GrantW-1:0] sel,
  output logic              any
);

  logic              hi_any, lo_any;
  logic [GrantW-1:0] hi_sel, lo_sel;

  // Scan downwards so the lowest index in each half wins.
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_sel = '0;
    lo_sel = '0;
    for (int c = NumReq - 1; c >= 0; c--) begin
      if (valid[c]) begin
        if (c >= int'(ptr)) begin
          hi_any = 1'b1;
          hi_sel = GrantW'(c);
        end else begin
          lo_any = 1'b1;
          lo_sel = GrantW'(c);
        end
      end
    end
    any = hi_any | lo_any;
    sel = hi_any ? hi_sel : lo_sel;
  end

endmodule

// File: rtl/hyperbus_trans_arbiter.sv
// Shares one HyperBus PHY between NumReq requesters. A requester is granted
// round-robin, its transaction is issued, then its write beats / write
// response or read beats are routed until the transfer completes.
//   req_* : per-requester transaction, tx, rx and b channels
//   rx_o / b_error_o : shared read beat / write response, qualified per requester
//   trans_*, tx_*, rx_*, b_* : PHY-facing channels
//   busy_o : FSM not idle;  grant_o : current grant index
module hyperbus_trans_arbiter
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumReq   = 2,
  parameter int unsigned NumChips = 2,
  parameter type hyper_tx_t = hyper_tx_beat_t,
  parameter type hyper_rx_t = hyper_rx_beat_t,
  localparam int unsigned GrantW = grant_width(NumReq)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  // Requester side
  input  logic [NumReq-1:0]   req_trans_valid_i,
  output logic [NumReq-1:0]   req_trans_ready_o,
  input  hyper_tf_t           req_trans_i [NumReq],
  input  logic [NumChips-1:0] req_cs_i    [NumReq],
  input  logic [NumReq-1:0]   req_tx_valid_i,
  output logic [NumReq-1:0]   req_tx_ready_o,
  input  hyper_tx_t           req_tx_i    [NumReq],
  output logic [NumReq-1:0]   req_rx_valid_o,
  input  logic [NumReq-1:0]   req_rx_ready_i,
  output hyper_rx_t           rx_o,
  output logic [NumReq-1:0]   req_b_valid_o,
  input  logic [NumReq-1:0]   req_b_ready_i,
  output logic                b_error_o,
  // PHY side
  output logic                trans_valid_o,
  input  logic                trans_ready_i,
  output hyper_tf_t           trans_o,
  output logic [NumChips-1:0] trans_cs_o,
  output logic                tx_valid_o,
  input  logic                tx_ready_i,
  output hyper_tx_t           tx_o,
  input  logic                rx_valid_i,
  output logic                rx_ready_o,
  input  hyper_rx_t           rx_i,
  input  logic                b_valid_i,
  output logic                b_ready_o,
  input  logic                b_error_i,
  // Status
  output logic                busy_o,
  output logic [GrantW-1:0]   grant_o
);

  arb_state_e        state_q;
  logic [GrantW-1:0] grant_q, rr_ptr_q, rr_next, arb_sel;
  logic              arb_any;

  hyperbus_trans_arbiter_rr #(
    .NumReq (NumReq)
  ) u_rr (
    .valid (req_trans_valid_i),
    .ptr   (rr_ptr_q),
    .sel   (arb_sel),
    .any   (arb_any)
  );

  assign rr_next = (grant_q == GrantW'(NumReq - 1)) ? '0 : grant_q + GrantW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (arb_any) begin
            grant_q <= arb_sel;
            state_q <= StIssue;
          end
        end
        // A requester withdrawing its request here simply keeps us waiting.
        StIssue: begin
          if (req_trans_valid_i[grant_q] && trans_ready_i) begin
            state_q <= req_trans_i[grant_q].write ? StWrite : StRead;
          end
        end
        StWrite: begin
          if (req_tx_valid_i[grant_q] && tx_ready_i && req_tx_i[grant_q].last) begin
            state_q <= StWaitB;
          end
        end
        StWaitB: begin
          if (b_valid_i && req_b_ready_i[grant_q]) begin
            state_q  <= StIdle;
            rr_ptr_q <= rr_next;
          end
        end
        StRead: begin
          if (rx_valid_i && req_rx_ready_i[grant_q] && rx_i.last) begin
            state_q  <= StIdle;
            rr_ptr_q <= rr_next;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Routing is purely combinational from state/grant so data sees no extra latency.
  always_comb begin
    req_trans_ready_o = '0;
    req_tx_ready_o    = '0;
    req_rx_valid_o    = '0;
    req_b_valid_o     = '0;
    trans_valid_o     = 1'b0;
    tx_valid_o        = 1'b0;
    rx_ready_o        = 1'b0;
    b_ready_o         = 1'b0;
    trans_o           = req_trans_i[grant_q];
    trans_cs_o        = req_cs_i[grant_q];
    tx_o              = req_tx_i[grant_q];
    rx_o              = rx_i;
    b_error_o         = b_error_i;
    case (state_q)
      StIssue: begin
        trans_valid_o              = req_trans_valid_i[grant_q];
        req_trans_ready_o[grant_q] = trans_ready_i;
      end
      StWrite: begin
        tx_valid_o              = req_tx_valid_i[grant_q];
        req_tx_ready_o[grant_q] = tx_ready_i;
      end
      StWaitB: begin
        req_b_valid_o[grant_q] = b_valid_i;
        b_ready_o              = req_b_ready_i[grant_q];
      end
      StRead: begin
        req_rx_valid_o[grant_q] = rx_valid_i;
        rx_ready_o              = req_rx_ready_i[grant_q];
      end
      default: ;
    endcase
  end

  assign busy_o  = (state_q != StIdle);
  assign grant_o = grant_q;

endmodule

// File: tb/tb_hyperbus_trans_arbiter.sv
// Directed self-checking bench for hyperbus_trans_arbiter (NumReq=2, NumChips=2).
module tb_hyperbus_trans_arbiter;
  import hyperbus_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic [1:0]           req_trans_valid_i, req_trans_ready_o;
  hyper_tf_t            req_trans_i [2];
  logic [1:0]           req_cs_i    [2];
  logic [1:0]           req_tx_valid_i, req_tx_ready_o;
  hyper_tx_beat_t       req_tx_i    [2];
  logic [1:0]           req_rx_valid_o, req_rx_ready_i;
  hyper_rx_beat_t       rx_o;
  logic [1:0]           req_b_valid_o, req_b_ready_i;
  logic                 b_error_o;
  logic                 trans_valid_o, trans_ready_i;
  hyper_tf_t            trans_o;
  logic [1:0]           trans_cs_o;
  logic                 tx_valid_o, tx_ready_i;
  hyper_tx_beat_t       tx_o;
  logic                 rx_valid_i, rx_ready_o;
  hyper_rx_beat_t       rx_i;
  logic                 b_valid_i, b_ready_o, b_error_i;
  logic                 busy_o;
  logic [0:0]           grant_o;

  int n_checks = 0;
  int n_pass   = 0;

  hyperbus_trans_arbiter dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .req_trans_valid_i (req_trans_valid_i),
    .req_trans_ready_o (req_trans_ready_o),
    .req_trans_i       (req_trans_i),
    .req_cs_i          (req_cs_i),
    .req_tx_valid_i    (req_tx_valid_i),
    .req_tx_ready_o    (req_tx_ready_o),
    .req_tx_i          (req_tx_i),
    .req_rx_valid_o    (req_rx_valid_o),
    .req_rx_ready_i    (req_rx_ready_i),
    .rx_o              (rx_o),
    .req_b_valid_o     (req_b_valid_o),
    .req_b_ready_i     (req_b_ready_i),
    .b_error_o         (b_error_o),
    .trans_valid_o     (trans_valid_o),
    .trans_ready_i     (trans_ready_i),
    .trans_o           (trans_o),
    .trans_cs_o        (trans_cs_o),
    .tx_valid_o        (tx_valid_o),
    .tx_ready_i        (tx_ready_i),
    .tx_o              (tx_o),
    .rx_valid_i        (rx_valid_i),
    .rx_ready_o        (rx_ready_o),
    .rx_i              (rx_i),
    .b_valid_i         (b_valid_i),
    .b_ready_o         (b_ready_o),
    .b_error_i         (b_error_i),
    .busy_o            (busy_o),
    .grant_o           (grant_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    req_trans_valid_i = '0;
    req_tx_valid_i    = '0;
    req_rx_ready_i    = '0;
    req_b_ready_i     = '0;
    trans_ready_i     = 1'b1;
    tx_ready_i        = 1'b0;
    rx_valid_i        = 1'b0;
    rx_i              = '0;
    b_valid_i         = 1'b0;
    b_error_i         = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_trans_i[i] = '0;
      req_cs_i[i]    = '0;
      req_tx_i[i]    = '0;
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
    check_eq({tag, "_ctrl"},
             32'({trans_valid_o, tx_valid_o, rx_ready_o, b_ready_o}), 32'd0);
    check_eq({tag, "_req"}, 32'({req_trans_ready_o, req_tx_ready_o, req_rx_valid_o,
                                 req_b_valid_o}), 32'd0);
    check_eq({tag, "_grant"}, 32'(grant_o), 32'd0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_inputs();
    #1;
    check_quiet("rst");
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic post(input int idx, input bit wr);
    req_trans_valid_i[idx] = 1'b1;
    req_trans_i[idx]       = '{write: wr, address: 32'h1000 + 32'(idx * 16), burst: 16'd4};
    req_cs_i[idx]          = 2'(1 << idx);
  endtask

  // Starts in IDLE with the request already posted.
  task automatic issue(input int idx, input bit wr);
    tick();
    check_eq("iss_grant", 32'(grant_o), 32'(idx));
    check_eq("iss_valid", 32'(trans_valid_o), 32'd1);
    check_eq("iss_busy", 32'(busy_o), 32'd1);
    check_eq("iss_write", 32'(trans_o.write), 32'(wr));
    check_eq("iss_addr", trans_o.address, 32'h1000 + 32'(idx * 16));
    check_eq("iss_cs", 32'(trans_cs_o), 32'(1 << idx));
    check_eq("iss_ready", 32'(req_trans_ready_o), 32'(1 << idx));
    tick();
    req_trans_valid_i[idx] = 1'b0;
  endtask

  task automatic write_beats(input int idx, input int n, input bit berr);
    tx_ready_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      req_tx_valid_i[idx] = 1'b1;
      req_tx_i[idx]       = '{data: 16'hA000 + 16'(i), strb: 2'b11, last: (i == n - 1)};
      #1;
      check_eq("tx_valid", 32'(tx_valid_o), 32'd1);
      check_eq("tx_data", 32'(tx_o.data), 32'h0000A000 + 32'(i));
      check_eq("tx_ready", 32'(req_tx_ready_o), 32'(1 << idx));
      tick();
    end
    req_tx_valid_i[idx] = 1'b0;
    tx_ready_i          = 1'b0;
    b_valid_i           = 1'b1;
    b_error_i           = berr;
    req_b_ready_i       = 2'b11;
    #1;
    check_eq("b_valid", 32'(req_b_valid_o), 32'(1 << idx));
    check_eq("b_ready", 32'(b_ready_o), 32'd1);
    check_eq("b_error", 32'(b_error_o), 32'(berr));
    tick();
    b_valid_i     = 1'b0;
    req_b_ready_i = '0;
    #1;
    check_eq("b_done_busy", 32'(busy_o), 32'd0);
  endtask

  // Requester stalls every other cycle; a stray b beat is held off throughout.
  task automatic read_beats(input int idx, input int n, input int err_beat);
    int beat = 0;
    rx_valid_i = 1'b1;
    b_valid_i  = 1'b1;
    for (int cyc = 0; cyc < 4 * n && beat < n; cyc++) begin
      rx_i           = '{data: 16'hB000 + 16'(beat), last: (beat == n - 1),
                         error: (beat == err_beat)};
      req_rx_ready_i = (cyc % 2 == 0) ? 2'(1 << idx) : 2'b00;
      #1;
      check_eq("rx_valid", 32'(req_rx_valid_o), 32'(1 << idx));
      check_eq("rx_data", 32'(rx_o.data), 32'h0000B000 + 32'(beat));
      check_eq("rx_error", 32'(rx_o.error), 32'(beat == err_beat));
      check_eq("rx_ready", 32'(rx_ready_o), 32'(cyc % 2 == 0));
      check_eq("rd_b_ready", 32'({b_ready_o, req_b_valid_o}), 32'd0);
      tick();
      if (cyc % 2 == 0) beat++;
    end
    check_eq("rx_beats", 32'(beat), 32'(n));
    rx_valid_i     = 1'b0;
    b_valid_i      = 1'b0;
    req_rx_ready_i = '0;
    #1;
    check_eq("rd_done_busy", 32'(busy_o), 32'd0);
  endtask

  initial begin
    do_reset();

    // Single write from req0: one-cycle arbitration, four beats, response.
    post(0, 1'b1);
    #1;
    check_eq("idle_no_valid", 32'(trans_valid_o), 32'd0);
    issue(0, 1'b1);
    write_beats(0, 4, 1'b0);

    // Pointer now past req0, so req1 wins a simultaneous request.
    post(0, 1'b1);
    post(1, 1'b1);
    issue(1, 1'b1);
    write_beats(1, 1, 1'b1);
    issue(0, 1'b1);
    write_beats(0, 2, 1'b0);

    // From reset both requesters twice: 0 then 1 each round.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      post(0, 1'b1);
      post(1, 1'b1);
      issue(0, 1'b1);
      write_beats(0, 1, 1'b0);
      issue(1, 1'b1);
      write_beats(1, 1, 1'b0);
    end

    // req1 read of 8 beats with an error on the third beat.
    post(1, 1'b0);
    issue(1, 1'b0);
    read_beats(1, 8, 2);

    // Reset in the middle of a write abandons it.
    post(0, 1'b1);
    issue(0, 1'b1);
    tx_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_tx_valid_i[0] = 1'b1;
      req_tx_i[0]       = '{data: 16'hC000 + 16'(i), strb: 2'b11, last: 1'b0};
      tick();
    end
    rst_ni = 1'b0;
    #1;
    check_eq("midrst_tx", 32'({tx_valid_o, req_tx_ready_o}), 32'd0);
    check_quiet("midrst");
    tick();
    rst_ni = 1'b1;
    clear_inputs();
    post(1, 1'b0);
    issue(1, 1'b0);
    read_beats(1, 2, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
